// File: rtl/mult_table_pkg.sv
// Shared constants, response codes and FSM states for the times-table block.
// No logic of its own; latency is defined by the modules that import it.
// No backpressure is involved; declarations only.
package mult_table_pkg;

   localparam int OP_W_DEF  = 3;
   localparam int IDX_W_DEF = 2 * OP_W_DEF;
   localparam int DEPTH_DEF = 1 << IDX_W_DEF;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mult_table_mem.sv
// 2R1W register array holding the times table; storage itself is never reset.
// Read ports are registered: address in cycle N, data valid in cycle N+1 and held until next enable.
// No backpressure: every port is accepted every cycle; same-cycle write/read returns the old entry.
module mult_table_mem
   import mult_table_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int ENT_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [ENT_W-1:0] wdata,
   input  logic             rd_en_a,
   input  logic [IDX_W-1:0] raddr_a,
   output logic [ENT_W-1:0] rdata_a,
   input  logic             rd_en_b,
   input  logic [IDX_W-1:0] raddr_b,
   output logic [ENT_W-1:0] rdata_b
);

   localparam int DEPTH = 1 << IDX_W;

   logic [ENT_W-1:0] mem [DEPTH];

   // Single write port; contents are rebuilt by the init sequence, so no reset here.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Lookup read port: holds its last value between enables.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_a <= '0;
      end else if (rd_en_a) begin
         rdata_a <= mem[raddr_a];
      end
   end

   // Bus read port: holds its last value between enables.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_b <= '0;
      end else if (rd_en_b) begin
         rdata_b <= mem[raddr_b];
      end
   end

endmodule

// File: rtl/mult_table_axil.sv
// Writable times table, self-initialised after reset, served on a lookup port and an AXI4-Lite slave.
// Latency: lookup and AR both 1 cycle to data; B follows 1 cycle after both AW and W are held.
// Backpressure: one write and one read outstanding; readies drop until B / R handshake completes.
module mult_table_axil
   import mult_table_pkg::*;
#(
   parameter int OP_W   = OP_W_DEF,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_W-1:0]     a,
   input  logic [OP_W-1:0]     b,
   input  logic                read,
   output logic [2*OP_W-1:0]   result,
   output logic                result_valid,
   output logic                init_done,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready
);

   localparam int IDX_W = 2 * OP_W;
   localparam int ENT_W = 2 * OP_W;
   localparam int DEPTH = 1 << IDX_W;

   // ---------------- init FSM ----------------
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             init_we;
   logic             run;
   logic [ENT_W-1:0] init_prod;

   // State and fill counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Walk every index once, writing its product, then open the ports.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      init_we = 1'b0;
      case (state_q)
         S_INIT: begin
            init_we = 1'b1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_W'(DEPTH - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   assign run       = (state_q == S_RUN);
   assign init_done = run;
   assign init_prod = ENT_W'(idx_q[IDX_W-1:OP_W]) * ENT_W'(idx_q[OP_W-1:0]);

   // ---------------- AXI write channel ----------------
   logic             aw_got, w_got;
   logic [IDX_W-1:0] aw_idx;
   logic             aw_oor;
   logic [ENT_W-1:0] w_dat;
   logic             w_strb0;
   logic             aw_hs, w_hs, wr_fire;

   assign s_axi_awready = run && !aw_got && !s_axi_bvalid;
   assign s_axi_wready  = run && !w_got  && !s_axi_bvalid;
   assign aw_hs         = s_axi_awvalid && s_axi_awready;
   assign w_hs          = s_axi_wvalid  && s_axi_wready;
   assign wr_fire       = aw_got && w_got;

   // Capture AW and W independently; commit and raise B once both are held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_got       <= 1'b0;
         w_got        <= 1'b0;
         aw_idx       <= '0;
         aw_oor       <= 1'b0;
         w_dat        <= '0;
         w_strb0      <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_got <= 1'b1;
            aw_idx <= s_axi_awaddr[IDX_W+1:2];
            aw_oor <= |(s_axi_awaddr >> (IDX_W + 2));
         end
         if (w_hs) begin
            w_got   <= 1'b1;
            w_dat   <= s_axi_wdata[ENT_W-1:0];
            w_strb0 <= s_axi_wstrb[0];
         end
         if (wr_fire) begin
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
      end
   end

   // ---------------- AXI read channel ----------------
   logic ar_hs, ar_oor, rd_err;

   assign s_axi_arready = run && !s_axi_rvalid;
   assign ar_hs         = s_axi_arvalid && s_axi_arready;
   assign ar_oor        = |(s_axi_araddr >> (IDX_W + 2));

   // One read outstanding; response holds until rready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_axi_rvalid <= 1'b0;
         rd_err       <= 1'b0;
      end else if (ar_hs) begin
         s_axi_rvalid <= 1'b1;
         rd_err       <= ar_oor;
      end else if (s_axi_rvalid && s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   // ---------------- lookup port ----------------
   // Pulse marks the cycle the lookup data register was refreshed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_valid <= 1'b0;
      end else begin
         result_valid <= run && read;
      end
   end

   // ---------------- storage ----------------
   logic             mem_we;
   logic [IDX_W-1:0] mem_waddr;
   logic [ENT_W-1:0] mem_wdata;
   logic [ENT_W-1:0] mem_rdata_b;

   assign mem_we    = init_we || (wr_fire && !aw_oor && w_strb0);
   assign mem_waddr = init_we ? idx_q     : aw_idx;
   assign mem_wdata = init_we ? init_prod : w_dat;

   mult_table_mem #(
      .IDX_W (IDX_W),
      .ENT_W (ENT_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we      (mem_we),
      .waddr   (mem_waddr),
      .wdata   (mem_wdata),
      .rd_en_a (run && read),
      .raddr_a ({a, b}),
      .rdata_a (result),
      .rd_en_b (ar_hs && !ar_oor),
      .raddr_b (s_axi_araddr[IDX_W+1:2]),
      .rdata_b (mem_rdata_b)
   );

   assign s_axi_rdata = rd_err ? '0 : DATA_W'(mem_rdata_b);
   assign s_axi_rresp = rd_err ? RESP_SLVERR : RESP_OKAY;

   // Byte offset, upper data bits and upper strobes carry no meaning for this table.
   logic unused_bits;
   assign unused_bits = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                          s_axi_wdata[DATA_W-1:ENT_W], s_axi_wstrb[DATA_W/8-1:1]};

endmodule
